// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared state encoding and count-width helper for vote_tally
package vote_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] VOTE = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Bits needed to hold a count from 0 up to and including n
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vote_popcount.sv
// rtl/vote_popcount.sv - combinational popcount over N bits
import vote_pkg::*;

module vote_popcount #(
  parameter int N  = 3,
  parameter int CW = cw_of(N)
) (
  input  logic [N-1:0]  bits_i,
  output logic [CW-1:0] count_o
);

  // Ripple-add every set bit; N is small (<= 32) so a simple chain is fine
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/vote_tally.sv
// rtl/vote_tally.sv - session-based yes-vote tally with threshold result; optional VOTE_TIMEOUT_EN
import vote_pkg::*;

module vote_tally #(
  parameter int N_VOTERS  = 3,
  parameter int THRESHOLD = 2,
  parameter int TIMEOUT   = 1000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic                          close,
  input  logic [N_VOTERS-1:0]           vote_valid,
  input  logic [N_VOTERS-1:0]           vote_yes,
  output logic                          busy,
  output logic [N_VOTERS-1:0]           voted,
  output logic [cw_of(N_VOTERS)-1:0]    yes_cnt,
  output logic                          result_valid,
  output logic                          result_pass
);

  localparam int            CW  = cw_of(N_VOTERS);
  localparam logic [CW-1:0] THR = CW'(THRESHOLD);

  logic [1:0]          state_q, state_d;
  logic [N_VOTERS-1:0] voted_q, voted_d;
  logic [CW-1:0]       yes_q, yes_d;
  logic                pass_q, pass_d;

  logic [N_VOTERS-1:0] accept;
  logic [CW-1:0]       new_yes;
  logic                all_voted;
  logic                timeout_hit;
  logic                close_now;

  // First vote from each voter only; repeats are silently dropped
  assign accept    = vote_valid & ~voted_q;
  assign all_voted = &(voted_q | accept);
  assign close_now = close | all_voted | timeout_hit;

  vote_popcount #(
    .N  (N_VOTERS),
    .CW (CW)
  ) u_popcount (
    .bits_i  (accept & vote_yes),
    .count_o (new_yes)
  );

`ifdef VOTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] timer_q;

  assign timeout_hit = (state_q == VOTE) && (timer_q == TW'(TIMEOUT - 1));

  // Session timer: cleared when a session opens, counts every VOTE cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
    end else if (start && (state_q != VOTE)) begin
      timer_q <= '0;
    end else if (state_q == VOTE) begin
      timer_q <= timer_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT < 2);
  assign timeout_hit        = 1'b0;
`endif

  // Session FSM and tally next-state; the closing cycle still counts its votes
  always_comb begin
    state_d = state_q;
    voted_d = voted_q;
    yes_d   = yes_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = VOTE;
          voted_d = '0;
          yes_d   = '0;
          pass_d  = 1'b0;
        end
      end
      VOTE: begin
        voted_d = voted_q | accept;
        yes_d   = yes_q + new_yes;
        if (close_now) begin
          state_d = DONE;
          pass_d  = (yes_d >= THR);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and tally registers; reset discards any open session
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      voted_q <= '0;
      yes_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      voted_q <= voted_d;
      yes_q   <= yes_d;
      pass_q  <= pass_d;
    end
  end

  assign busy         = (state_q == VOTE);
  assign result_valid = (state_q == DONE);
  assign result_pass  = pass_q;
  assign voted        = voted_q;
  assign yes_cnt      = yes_q;

endmodule

// File: tb/tb_vote_tally.sv
// tb/tb_vote_tally.sv - directed self-checking bench for vote_tally
module tb_vote_tally;

  logic       clk = 1'b0;
  logic       resetn;
  logic       st;
  logic       cl;
  logic [2:0] vv;
  logic [2:0] vy;
  logic       busy;
  logic [2:0] voted;
  logic [1:0] yes_cnt;
  logic       result_valid;
  logic       result_pass;

  int errors = 0;
  int checks = 0;

  vote_tally #(
    .N_VOTERS  (3),
    .THRESHOLD (2),
    .TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (st),
    .close        (cl),
    .vote_valid   (vv),
    .vote_yes     (vy),
    .busy         (busy),
    .voted        (voted),
    .yes_cnt      (yes_cnt),
    .result_valid (result_valid),
    .result_pass  (result_pass)
  );

  always #5 clk = ~clk;

  // Apply inputs for one clock, land on the following falling edge, idle inputs
  task automatic cycle(input logic s, input logic c, input logic [2:0] v, input logic [2:0] y);
    st = s; cl = c; vv = v; vy = y;
    @(posedge clk);
    @(negedge clk);
    st = 1'b0; cl = 1'b0; vv = 3'b000; vy = 3'b000;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    st = 1'b0; cl = 1'b0; vv = 3'b000; vy = 3'b000;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (voted !== 3'b000) begin errors++; $display("FAIL reset_voted got=%b exp=000", voted); end
    checks++; if (yes_cnt !== 2'd0) begin errors++; $display("FAIL reset_yes_cnt got=%0d exp=0", yes_cnt); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid got=%b exp=0", result_valid); end
    checks++; if (result_pass !== 1'b0) begin errors++; $display("FAIL reset_result_pass got=%b exp=0", result_pass); end
    // Votes and close in IDLE are ignored
    cycle(1'b0, 1'b1, 3'b111, 3'b111);
    checks++; if (voted !== 3'b000) begin errors++; $display("FAIL idle_ignore_voted got=%b exp=000", voted); end
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL idle_ignore_state busy=%b rv=%b exp=0/0", busy, result_valid); end
  endtask

  task automatic test_all_vote();
    cycle(1'b1, 1'b0, 3'b000, 3'b000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL allvote_busy got=%b exp=1", busy); end
    cycle(1'b0, 1'b0, 3'b111, 3'b011);
    checks++; if (yes_cnt !== 2'd2) begin errors++; $display("FAIL allvote_yes_cnt got=%0d exp=2", yes_cnt); end
    checks++; if (busy !== 1'b0 || result_valid !== 1'b1) begin errors++; $display("FAIL allvote_done busy=%b rv=%b exp=0/1", busy, result_valid); end
    checks++; if (result_pass !== 1'b1) begin errors++; $display("FAIL allvote_pass got=%b exp=1", result_pass); end
    checks++; if (voted !== 3'b111) begin errors++; $display("FAIL allvote_voted got=%b exp=111", voted); end
  endtask

  task automatic test_majority();
    logic [2:0] pv;
    logic [1:0] exp_cnt;
    for (int p = 0; p < 8; p++) begin
      pv = p[2:0];
      exp_cnt = 2'(pv[0]) + 2'(pv[1]) + 2'(pv[2]);
      cycle(1'b1, 1'b0, 3'b000, 3'b000);
      cycle(1'b0, 1'b0, 3'b111, pv);
      checks++; if (yes_cnt !== exp_cnt) begin errors++; $display("FAIL maj_cnt yes=%b got=%0d exp=%0d", pv, yes_cnt, exp_cnt); end
      checks++; if (result_pass !== (exp_cnt >= 2'd2) || result_valid !== 1'b1) begin
        errors++; $display("FAIL maj_pass yes=%b got=%b rv=%b exp=%b", pv, result_pass, result_valid, exp_cnt >= 2'd2);
      end
    end
  endtask

  task automatic test_single_then_close();
    cycle(1'b1, 1'b0, 3'b000, 3'b000);
    cycle(1'b0, 1'b0, 3'b001, 3'b001);
    checks++; if (voted !== 3'b001 || yes_cnt !== 2'd1) begin errors++; $display("FAIL single_vote voted=%b cnt=%0d exp=001/1", voted, yes_cnt); end
    checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL single_open busy=%b rv=%b exp=1/0", busy, result_valid); end
    cycle(1'b0, 1'b1, 3'b000, 3'b000);
    checks++; if (result_valid !== 1'b1 || result_pass !== 1'b0) begin errors++; $display("FAIL single_result rv=%b pass=%b exp=1/0", result_valid, result_pass); end
    checks++; if (voted !== 3'b001 || yes_cnt !== 2'd1) begin errors++; $display("FAIL single_hold voted=%b cnt=%0d exp=001/1", voted, yes_cnt); end
    // Votes and close in DONE are ignored
    cycle(1'b0, 1'b1, 3'b110, 3'b110);
    checks++; if (voted !== 3'b001 || yes_cnt !== 2'd1 || result_valid !== 1'b1) begin
      errors++; $display("FAIL done_ignore voted=%b cnt=%0d rv=%b exp=001/1/1", voted, yes_cnt, result_valid);
    end
    // start in DONE reopens with cleared counters on the next edge
    cycle(1'b1, 1'b0, 3'b000, 3'b000);
    checks++; if (busy !== 1'b1 || result_valid !== 1'b0 || yes_cnt !== 2'd0 || voted !== 3'b000) begin
      errors++; $display("FAIL restart busy=%b rv=%b cnt=%0d voted=%b exp=1/0/0/000", busy, result_valid, yes_cnt, voted);
    end
    cycle(1'b0, 1'b1, 3'b000, 3'b000);
  endtask

  task automatic test_duplicate();
    cycle(1'b1, 1'b0, 3'b000, 3'b000);
    cycle(1'b0, 1'b0, 3'b010, 3'b010);
    cycle(1'b0, 1'b0, 3'b010, 3'b010);
    checks++; if (yes_cnt !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL dup_before_close cnt=%0d busy=%b exp=1/1", yes_cnt, busy); end
    cycle(1'b0, 1'b1, 3'b000, 3'b000);
    checks++; if (yes_cnt !== 2'd1 || voted !== 3'b010) begin errors++; $display("FAIL dup_final cnt=%0d voted=%b exp=1/010", yes_cnt, voted); end
  endtask

  task automatic test_close_same_cycle();
    cycle(1'b1, 1'b0, 3'b000, 3'b000);
    cycle(1'b0, 1'b1, 3'b100, 3'b100);
    checks++; if (yes_cnt !== 2'd1 || voted !== 3'b100) begin errors++; $display("FAIL close_same_cnt cnt=%0d voted=%b exp=1/100", yes_cnt, voted); end
    checks++; if (result_valid !== 1'b1 || busy !== 1'b0 || result_pass !== 1'b0) begin
      errors++; $display("FAIL close_same_result rv=%b busy=%b pass=%b exp=1/0/0", result_valid, busy, result_pass);
    end
  endtask

`ifdef VOTE_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    cycle(1'b1, 1'b0, 3'b000, 3'b000);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      cycle(1'b0, 1'b0, 3'b000, 3'b000);
    end
    checks++; if (n != 8) begin errors++; $display("FAIL timeout_len got=%0d exp=8", n); end
    checks++; if (result_valid !== 1'b1 || result_pass !== 1'b0) begin errors++; $display("FAIL timeout_result rv=%b pass=%b exp=1/0", result_valid, result_pass); end
  endtask
`endif

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 3'b000, 3'b000);
    cycle(1'b0, 1'b0, 3'b001, 3'b001);
    checks++; if (yes_cnt !== 2'd1) begin errors++; $display("FAIL mid_pre cnt=%0d exp=1", yes_cnt); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || voted !== 3'b000 || yes_cnt !== 2'd0 || result_valid !== 1'b0 || result_pass !== 1'b0) begin
      errors++; $display("FAIL mid_async busy=%b voted=%b cnt=%0d rv=%b pass=%b exp=all 0", busy, voted, yes_cnt, result_valid, result_pass);
    end
    @(negedge clk);
    resetn = 1'b1;
    cycle(1'b0, 1'b0, 3'b000, 3'b000);
    checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_no_result rv=%b busy=%b exp=0/0", result_valid, busy); end
    cycle(1'b1, 1'b0, 3'b000, 3'b000);
    checks++; if (busy !== 1'b1 || yes_cnt !== 2'd0 || voted !== 3'b000) begin
      errors++; $display("FAIL mid_clean busy=%b cnt=%0d voted=%b exp=1/0/000", busy, yes_cnt, voted);
    end
  endtask

  initial begin
    test_reset();
    test_all_vote();
    test_majority();
    test_single_then_close();
    test_duplicate();
    test_close_same_cycle();
`ifdef VOTE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
